// File: rtl/jt12_kon_pkg.sv
// Shared types and slot-mapping helpers for the key-on scheduler.
package jt12_kon_pkg;

  localparam int SLOTS = 24;
  localparam int CHANS = 6;
  localparam int GRPS  = 4;

  // Operator select: index of the op bit inside {S4,S3,S2,S1}
  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S2 = 2'd1,
    OP_S3 = 2'd2,
    OP_S4 = 2'd3
  } op_sel_e;

  // Operator served by each slot group, packed grp3..grp0 (slot order S1,S3,S2,S4)
  localparam logic [7:0] GRP_ORDER = {OP_S4, OP_S2, OP_S3, OP_S1};

  // Channel index of channel 3, the one CSM forces
  localparam logic [2:0] CSM_CHIDX = 3'd2;

  // CSM key-on arm/force state
  typedef enum logic [1:0] {
    CSM_IDLE  = 2'd0,
    CSM_ARMED = 2'd1,
    CSM_FORCE = 2'd2
  } csm_state_e;

  // Register 0x28 channel code -> {valid, chidx}; codes 3 and 7 are invalid
  function automatic logic [3:0] ch2idx(input logic [2:0] ch);
    logic       ok;
    logic [2:0] idx;
    ok = (ch[1:0] != 2'b11);
    if (ch[2]) begin
      idx = {1'b0, ch[1:0]} + 3'd3;
    end else begin
      idx = {1'b0, ch[1:0]};
    end
    return {ok, idx};
  endfunction

  // Slot number of a (group, channel index) pair
  function automatic logic [4:0] slot_of(input logic [1:0] grp, input logic [2:0] chidx);
    logic [4:0] g5;
    g5 = {3'b000, grp};
    return (g5 * 5'(CHANS)) + {2'b00, chidx};
  endfunction

  // Group (0..3) a slot belongs to
  function automatic logic [1:0] grp_of_slot(input logic [4:0] slot);
    logic [1:0] g;
    if (slot < 5'd6) begin
      g = 2'd0;
    end else if (slot < 5'd12) begin
      g = 2'd1;
    end else if (slot < 5'd18) begin
      g = 2'd2;
    end else begin
      g = 2'd3;
    end
    return g;
  endfunction

  // Index of the latched op bit that drives a given slot
  function automatic logic [1:0] op_of_slot(input logic [4:0] slot);
    logic [1:0] g;
    g = grp_of_slot(slot);
    return GRP_ORDER[{g, 1'b0} +: 2];
  endfunction

  // The four slots of one channel
  function automatic logic [SLOTS-1:0] chan_mask(input logic [2:0] chidx);
    logic [SLOTS-1:0] m;
    m = {SLOTS{1'b0}};
    for (int g = 0; g < GRPS; g++) begin
      m[slot_of(2'(g), chidx)] = 1'b1;
    end
    return m;
  endfunction

  // True for the channel-3 slots covered by a CSM force
  function automatic logic is_csm_slot(input logic [4:0] slot);
    logic [SLOTS-1:0] m;
    m = chan_mask(CSM_CHIDX);
    return m[slot];
  endfunction

endpackage

// File: rtl/jt12_kon_slotcnt.sv
// Operator-slot counter: advances on clk_en, wraps 23 -> 0, resyncs on zero.
module jt12_kon_slotcnt #(
  parameter int ZERO_SLOT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       zero,
  output logic [4:0] slot,
  output logic [4:0] slot_nxt
);
  import jt12_kon_pkg::*;

  localparam logic [4:0] ZSLOT = 5'(ZERO_SLOT);
  localparam logic [4:0] LAST  = 5'(SLOTS - 1);

  // Next slot: hold without clk_en, zero resync has priority over the wrap
  always_comb begin
    slot_nxt = slot;
    if (!clk_en) begin
      slot_nxt = slot;
    end else if (zero) begin
      slot_nxt = ZSLOT;
    end else if (slot == LAST) begin
      slot_nxt = 5'd0;
    end else begin
      slot_nxt = slot + 5'd1;
    end
  end

  // Slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= 5'd0;
    end else begin
      slot <= slot_nxt;
    end
  end

endmodule

// File: rtl/jt12_kon_sched.sv
// Key-on scheduler: holds the 24-slot key-on state written via 0x28, commits
// writes slot by slot as each target slot comes round, and replays the state
// (plus the CSM channel-3 force) as keyon_I in operator-slot time.
module jt12_kon_sched #(
  parameter int CSM       = 1,
  parameter int ZERO_SLOT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       zero,
  input  logic       kon_we,
  input  logic [2:0] kon_ch,
  input  logic [3:0] kon_op,
  output logic       kon_ready,
  output logic       kon_err,
  input  logic       csm_en,
  input  logic       tmr_a_ovf,
  output logic [4:0] slot_I,
  output logic       keyon_I
);
  import jt12_kon_pkg::*;

  localparam logic CSM_ON = (CSM != 0);

  logic [4:0]       slot_nxt;
  logic [SLOTS-1:0] kon_state, kon_state_nxt;
  logic [SLOTS-1:0] pend, pend_nxt;
  logic [3:0]       op_lat, op_lat_nxt;
  logic             ready_nxt, err_nxt, keyon_nxt;
  logic [3:0]       ch_info;
  logic             ch_ok;
  logic [2:0]       ch_idx;
  logic             accept;
  logic             csm_arm, rev_start;
  csm_state_e       csm_state, csm_state_nxt;
  logic             csm_rearm, csm_rearm_nxt;

  jt12_kon_slotcnt #(
    .ZERO_SLOT (ZERO_SLOT)
  ) u_slotcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .zero     (zero),
    .slot     (slot_I),
    .slot_nxt (slot_nxt)
  );

  assign ch_info   = ch2idx(kon_ch);
  assign ch_ok     = ch_info[3];
  assign ch_idx    = ch_info[2:0];
  // A write is only taken while idle; busy-time kon_we is left to the producer
  assign accept    = kon_we & kon_ready;
  assign csm_arm   = CSM_ON & tmr_a_ovf & csm_en;
  // A new revolution begins on the edge that presents slot 0
  assign rev_start = clk_en & (slot_nxt == 5'd0);

  // Write acceptance and per-slot commit of the latched op bits
  always_comb begin
    kon_state_nxt = kon_state;
    pend_nxt      = pend;
    op_lat_nxt    = op_lat;
    err_nxt       = 1'b0;
    if (clk_en && pend[slot_I]) begin
      kon_state_nxt[slot_I] = op_lat[op_of_slot(slot_I)];
      pend_nxt[slot_I]      = 1'b0;
    end else begin
      kon_state_nxt = kon_state;
    end
    // pend is empty whenever accept is possible, so no commit collides here
    if (accept) begin
      if (ch_ok) begin
        op_lat_nxt = kon_op;
        pend_nxt   = chan_mask(ch_idx);
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      err_nxt = 1'b0;
    end
    ready_nxt = (pend_nxt == {SLOTS{1'b0}});
  end

  // CSM force sequencing: arm on overflow, force one revolution from slot 0
  always_comb begin
    csm_state_nxt = csm_state;
    csm_rearm_nxt = csm_rearm;
    case (csm_state)
      CSM_IDLE: begin
        csm_rearm_nxt = 1'b0;
        if (csm_arm) begin
          csm_state_nxt = CSM_ARMED;
        end else begin
          csm_state_nxt = CSM_IDLE;
        end
      end
      CSM_ARMED: begin
        if (rev_start) begin
          csm_state_nxt = CSM_FORCE;
          csm_rearm_nxt = csm_arm;
        end else begin
          csm_state_nxt = CSM_ARMED;
          csm_rearm_nxt = 1'b0;
        end
      end
      CSM_FORCE: begin
        if (rev_start) begin
          // A queued re-arm extends the force by one more revolution
          if (csm_rearm) begin
            csm_state_nxt = CSM_FORCE;
          end else if (csm_arm) begin
            csm_state_nxt = CSM_ARMED;
          end else begin
            csm_state_nxt = CSM_IDLE;
          end
          csm_rearm_nxt = csm_rearm & csm_arm;
        end else begin
          csm_state_nxt = CSM_FORCE;
          csm_rearm_nxt = csm_rearm | csm_arm;
        end
      end
      default: begin
        csm_state_nxt = CSM_IDLE;
        csm_rearm_nxt = 1'b0;
      end
    endcase
  end

  // keyon_I is computed for the slot about to be presented so both align
  always_comb begin
    if (clk_en) begin
      keyon_nxt = kon_state_nxt[slot_nxt] |
                  ((csm_state_nxt == CSM_FORCE) & is_csm_slot(slot_nxt));
    end else begin
      keyon_nxt = keyon_I;
    end
  end

  // Key-on state, pending write, handshake and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kon_state <= {SLOTS{1'b0}};
      pend      <= {SLOTS{1'b0}};
      op_lat    <= 4'b0000;
      kon_ready <= 1'b1;
      kon_err   <= 1'b0;
      keyon_I   <= 1'b0;
    end else begin
      kon_state <= kon_state_nxt;
      pend      <= pend_nxt;
      op_lat    <= op_lat_nxt;
      kon_ready <= ready_nxt;
      kon_err   <= err_nxt;
      keyon_I   <= keyon_nxt;
    end
  end

  // CSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csm_state <= CSM_IDLE;
      csm_rearm <= 1'b0;
    end else begin
      csm_state <= csm_state_nxt;
      csm_rearm <= csm_rearm_nxt;
    end
  end

endmodule
